// File: rtl/fifo_read_ctrl_pkg.sv
// Shared types and helpers for the async FIFO read/write controllers.
package async_fifo_pkg;

    localparam int DefaultPtrWidth = 2;

    typedef logic [DefaultPtrWidth:0] ptr_t;

    // Operates on a wide vector so callers of any pointer width can slice the result.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/fifo_read_ctrl_if.sv
// Read-domain FIFO controller signal bundle; master drives requests, slave is the controller.
interface fifo_read_ctrl_if #(
    parameter int PtrWidth   = 2,
    parameter int LevelWidth = PtrWidth + 1
);
    logic                  i_rd_en;
    logic [PtrWidth:0]     i_wr_gray_ptr_sync;
    logic [LevelWidth-1:0] i_ae_thresh;
    logic                  i_clr_underflow;
    logic                  o_rd_accept;
    logic [PtrWidth-1:0]   o_rd_addr;
    logic [PtrWidth:0]     o_rd_bin_ptr;
    logic [PtrWidth:0]     o_rd_gray_ptr;
    logic                  o_empty;
    logic                  o_almost_empty;
    logic [LevelWidth-1:0] o_level;
    logic                  o_underflow;

    modport master (
        output i_rd_en, i_wr_gray_ptr_sync, i_ae_thresh, i_clr_underflow,
        input  o_rd_accept, o_rd_addr, o_rd_bin_ptr, o_rd_gray_ptr,
               o_empty, o_almost_empty, o_level, o_underflow
    );

    modport slave (
        input  i_rd_en, i_wr_gray_ptr_sync, i_ae_thresh, i_clr_underflow,
        output o_rd_accept, o_rd_addr, o_rd_bin_ptr, o_rd_gray_ptr,
               o_empty, o_almost_empty, o_level, o_underflow
    );
endinterface

// File: rtl/fifo_read_ctrl_gray2bin.sv
// Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
    parameter int Width = 3
) (
    input  logic [Width-1:0] gray_i,
    output logic [Width-1:0] bin_o
);
    for (genvar gi = 0; gi < Width; gi++) begin : g_bit
        assign bin_o[gi] = ^gray_i[Width-1:gi];
    end
endmodule

// File: rtl/fifo_read_ctrl.sv
// Async FIFO read-domain controller: read pointer, empty/level/almost-empty status, sticky underflow.
// Level and threshold status are built only when ASYNC_FIFO_RD_LEVEL_EN is defined.
module fifo_read_ctrl
    import async_fifo_pkg::*;
#(
    parameter int PtrWidth   = DefaultPtrWidth,
    parameter int LevelWidth = PtrWidth + 1
) (
    input  logic              clk,
    input  logic              rst,
    fifo_read_ctrl_if.slave   bus
);
    logic [PtrWidth:0] rd_bin_q, rd_bin_d;
    logic [PtrWidth:0] rd_gray_q, rd_gray_d;
    logic [PtrWidth:0] wr_bin;
    logic [31:0]       gray_wide;
    logic              empty_q, empty_d;
    logic              underflow_q, underflow_d;
    logic              rd_accept;

    gray2bin #(.Width(PtrWidth + 1)) u_wr_g2b (
        .gray_i (bus.i_wr_gray_ptr_sync),
        .bin_o  (wr_bin)
    );

    assign gray_wide = bin2gray(32'(rd_bin_d));

    always_comb begin
        rd_accept   = bus.i_rd_en & ~empty_q & ~rst;
        rd_bin_d    = rd_bin_q + (PtrWidth + 1)'(rd_accept);
        rd_gray_d   = gray_wide[PtrWidth:0];
        // Status follows the post-read pointer so the final read flags empty on its own edge.
        empty_d     = (rd_bin_d == wr_bin);
        // A fresh underflow beats a simultaneous clear.
        underflow_d = (bus.i_rd_en & empty_q) | (underflow_q & ~bus.i_clr_underflow);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_bin_q    <= '0;
            rd_gray_q   <= '0;
            empty_q     <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            rd_bin_q    <= rd_bin_d;
            rd_gray_q   <= rd_gray_d;
            empty_q     <= empty_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef ASYNC_FIFO_RD_LEVEL_EN
    logic [PtrWidth:0]     level_diff;
    logic [LevelWidth-1:0] level_q, level_d;
    logic                  ae_q, ae_d;
    logic                  unused_bits;

    always_comb begin
        level_diff = wr_bin - rd_bin_d;
        level_d    = LevelWidth'(level_diff);
        ae_d       = (level_d <= bus.i_ae_thresh);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
            ae_q    <= 1'b1;
        end else begin
            level_q <= level_d;
            ae_q    <= ae_d;
        end
    end

    assign unused_bits        = ^gray_wide[31:PtrWidth+1];
    assign bus.o_level        = level_q;
    assign bus.o_almost_empty = ae_q;
`else
    logic unused_bits;

    assign unused_bits        = ^{gray_wide[31:PtrWidth+1], bus.i_ae_thresh};
    assign bus.o_level        = '0;
    assign bus.o_almost_empty = empty_q;
`endif

    assign bus.o_rd_accept   = rd_accept;
    assign bus.o_rd_addr     = rd_bin_q[PtrWidth-1:0];
    assign bus.o_rd_bin_ptr  = rd_bin_q;
    assign bus.o_rd_gray_ptr = rd_gray_q;
    assign bus.o_empty       = empty_q;
    assign bus.o_underflow   = underflow_q;
endmodule
